// File: rtl/uart_rx_cfg_pkg.sv
// Shared types and constants for the configurable UART receiver.
// Standard divisors assume a 50 MHz clk.
package uart_rx_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [1:0] DBITS_5 = 2'd0;
  localparam logic [1:0] DBITS_6 = 2'd1;
  localparam logic [1:0] DBITS_7 = 2'd2;
  localparam logic [1:0] DBITS_8 = 2'd3;

  localparam int DIV_115200 = 434;
  localparam int DIV_9600   = 5208;
  localparam int DIV_MIN    = 8;

  // Rate selects of the fixed-rate 8N1 receiver, still referenced by older blocks.
  localparam logic [1:0] BAUD_9600   = 2'd0;
  localparam logic [1:0] BAUD_19200  = 2'd1;
  localparam logic [1:0] BAUD_57600  = 2'd2;
  localparam logic [1:0] BAUD_115200 = 2'd3;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_sampler.sv
// Line synchroniser, start-edge detect and 3-sample majority vote.
// bit_vld marks the decision cycle (cnt_baud == half+1); the caller gates it by state.
module uart_rx_sampler
  import uart_rx_cfg_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_din,
  input  logic [DIV_W-1:0] cnt_baud,
  input  logic [DIV_W-1:0] half,
  output logic             rx_fall,
  output logic             bit_val,
  output logic             bit_vld
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   s0_q;
  logic                   s1_q;

  // sync_q[0] is the newest stage; the edge is seen between the last two.
  assign rx_s    = sync_q[SYNC_STAGES-2];
  assign rx_fall = sync_q[SYNC_STAGES-1] & ~rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_din};
      if (cnt_baud == half - DIV_W'(1)) s0_q <= rx_s;
      if (cnt_baud == half)             s1_q <= rx_s;
    end
  end

  assign bit_vld = (cnt_baud == half + DIV_W'(1));
  assign bit_val = maj3(s0_q, s1_q, rx_s);

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5-8 data bits, optional parity, 1/2 stop bits.
// Frame config is latched at the start edge so mid-frame changes are ignored.
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       data_bits,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  input  logic             rx_din,
  output logic [7:0]       rx_byte,
  output logic             rx_byte_vld,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  rx_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] half;
  logic [1:0]       nbits_q;
  logic             pen_q, podd_q, stop2_q;
  logic [2:0]       bit_idx_q;
  logic             stop_idx_q;
  logic             stop_bad_q;
  logic             perr_q;
  logic [7:0]       shreg_q;
  logic             rx_fall, bit_val, bit_vld;
  logic             last_data, last_stop;

  assign half = div_q >> 1;

  uart_rx_sampler #(
    .DIV_W      (DIV_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_din  (rx_din),
    .cnt_baud(cnt_q),
    .half    (half),
    .rx_fall (rx_fall),
    .bit_val (bit_val),
    .bit_vld (bit_vld)
  );

  assign last_data = (bit_idx_q == ({1'b0, nbits_q} + 3'd4));
  assign last_stop = (stop_idx_q == stop2_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (rx_fall) state_d = ST_START;
      ST_START:  if (bit_vld) state_d = bit_val ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_vld && last_data) state_d = pen_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_vld) state_d = ST_STOP;
      ST_STOP:   if (bit_vld && last_stop) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      div_q       <= DIV_W'(DIV_MIN);
      nbits_q     <= DBITS_8;
      pen_q       <= 1'b0;
      podd_q      <= 1'b0;
      stop2_q     <= 1'b0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      stop_bad_q  <= 1'b0;
      perr_q      <= 1'b0;
      shreg_q     <= '0;
      rx_byte     <= '0;
      rx_byte_vld <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_byte_vld <= 1'b0;
      if (state_q == ST_IDLE) begin
        cnt_q <= '0;
        if (rx_fall) begin
          div_q      <= (baud_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : baud_div;
          nbits_q    <= data_bits;
          pen_q      <= parity_en;
          podd_q     <= parity_odd;
          stop2_q    <= stop2;
          bit_idx_q  <= '0;
          stop_idx_q <= 1'b0;
          stop_bad_q <= 1'b0;
          perr_q     <= 1'b0;
          shreg_q    <= '0;
        end
      end else begin
        cnt_q <= (cnt_q == div_q - DIV_W'(1)) ? '0 : cnt_q + DIV_W'(1);
      end

      if (bit_vld) begin
        case (state_q)
          ST_DATA: begin
            shreg_q[bit_idx_q] <= bit_val;
            bit_idx_q          <= bit_idx_q + 3'd1;
          end
          // Unused upper bits of shreg_q are 0, so they do not disturb the XOR.
          ST_PARITY: perr_q <= (bit_val != ((^shreg_q) ^ podd_q));
          ST_STOP: begin
            if (last_stop) begin
              rx_byte     <= shreg_q;
              parity_err  <= perr_q;
              frame_err   <= stop_bad_q | ~bit_val;
              rx_byte_vld <= 1'b1;
            end else begin
              stop_idx_q <= 1'b1;
              stop_bad_q <= ~bit_val;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: frames are driven per clock slot and every
// received byte is queued as {parity_err, frame_err, rx_byte} for the tests to compare.
module tb_uart_rx_cfg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baud_div;
  logic [1:0]  data_bits;
  logic        parity_en, parity_odd, stop2;
  logic        rx_din;
  logic [7:0]  rx_byte;
  logic        rx_byte_vld, parity_err, frame_err, busy;

  int tests = 0;
  int fails = 0;
  int bit_clks = 8;
  logic [9:0] rxq[$];

  uart_rx_cfg #(.DIV_W(16), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_div   (baud_div),
    .data_bits  (data_bits),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .rx_din     (rx_din),
    .rx_byte    (rx_byte),
    .rx_byte_vld(rx_byte_vld),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && rx_byte_vld) rxq.push_back({parity_err, frame_err, rx_byte});

  task automatic cfg(input int div, input logic [1:0] db, input logic pen, input logic podd,
                     input logic st2);
    baud_div   = 16'(div);
    data_bits  = db;
    parity_en  = pen;
    parity_odd = podd;
    stop2      = st2;
    bit_clks   = (div < 8) ? 8 : div;
    rxq.delete();
  endtask

  // glitch: slot index (clocks from the start-bit fall) that is driven inverted, -1 for none
  task automatic send_frame(input logic [7:0] data, input int nbits, input logic pen,
                            input logic pbit, input logic st2, input logic stop2_val,
                            input int glitch, input int idle);
    logic b[$];
    int   s;
    s = 0;
    b.push_back(1'b0);
    for (int i = 0; i < nbits; i++) b.push_back(data[i]);
    if (pen) b.push_back(pbit);
    b.push_back(1'b1);
    if (st2) b.push_back(stop2_val);
    foreach (b[i]) begin
      for (int c = 0; c < bit_clks; c++) begin
        @(negedge clk);
        rx_din = (s == glitch) ? ~b[i] : b[i];
        s++;
      end
    end
    repeat (idle) begin
      @(negedge clk);
      rx_din = 1'b1;
    end
  endtask

  function automatic logic [9:0] pop_rx();
    if (rxq.size() == 0) return 10'h3FF;
    return rxq.pop_front();
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    rx_din = 1'b1;
    cfg(434, 2'd3, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    tests++;
    if ({rx_byte_vld, parity_err, frame_err, busy, rx_byte} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs got %h exp 000", {rx_byte_vld, parity_err, frame_err, busy, rx_byte});
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    tests++;
    if ({rx_byte_vld, busy} !== 2'b00 || rxq.size() != 0) begin
      fails++;
      $display("FAIL reset_release got vld/busy %b q %0d exp 00 q 0", {rx_byte_vld, busy}, rxq.size());
    end
  endtask

  task automatic test_8n1();
    logic [9:0] g;
    cfg(434, 2'd3, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 20);
    tests++;
    if (rxq.size() != 1) begin fails++; $display("FAIL 8n1_count got %0d exp 1", rxq.size()); end
    g = pop_rx();
    tests++;
    if (g !== 10'h0A5) begin fails++; $display("FAIL 8n1_byte got %h exp 0a5", g); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL 8n1_busy got %b exp 0", busy); end
  endtask

  task automatic test_7e1();
    logic [9:0] g;
    cfg(52, 2'd2, 1'b1, 1'b0, 1'b0);
    send_frame(8'h35, 7, 1'b1, 1'b0, 1'b0, 1'b1, -1, 20);
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b0, 1'b1, -1, 20);
    tests++;
    if (rxq.size() != 2) begin fails++; $display("FAIL 7e1_count got %0d exp 2", rxq.size()); end
    g = pop_rx();
    tests++;
    if (g !== 10'h035) begin fails++; $display("FAIL 7e1_good got %h exp 035", g); end
    g = pop_rx();
    tests++;
    if (g !== 10'h235) begin fails++; $display("FAIL 7e1_perr got %h exp 235", g); end
  endtask

  task automatic test_8n2();
    logic [9:0] g;
    cfg(52, 2'd3, 1'b0, 1'b0, 1'b1);
    send_frame(8'hC6, 8, 1'b0, 1'b0, 1'b1, 1'b0, -1, 20);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, -1, 20);
    tests++;
    if (rxq.size() != 2) begin fails++; $display("FAIL 8n2_count got %0d exp 2", rxq.size()); end
    g = pop_rx();
    tests++;
    if (g !== 10'h1C6) begin fails++; $display("FAIL 8n2_ferr got %h exp 1c6", g); end
    g = pop_rx();
    tests++;
    if (g !== 10'h03C) begin fails++; $display("FAIL 8n2_clear got %h exp 03c", g); end
  endtask

  task automatic test_false_start();
    logic [9:0] g;
    cfg(434, 2'd3, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      rx_din = 1'b0;
      if (c == 50) begin
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL fs_busy_hi got %b exp 1", busy); end
      end
    end
    repeat (400) begin
      @(negedge clk);
      rx_din = 1'b1;
    end
    tests++;
    if (busy !== 1'b0 || rxq.size() != 0) begin
      fails++;
      $display("FAIL fs_reject got busy %b q %0d exp busy 0 q 0", busy, rxq.size());
    end
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 20);
    g = pop_rx();
    tests++;
    if (g !== 10'h05A || rxq.size() != 0) begin
      fails++;
      $display("FAIL fs_next got %h extra %0d exp 05a extra 0", g, rxq.size());
    end
  endtask

  task automatic test_majority();
    logic [9:0] g;
    cfg(434, 2'd3, 1'b0, 1'b0, 1'b0);
    // data bit 3 is line bit 4; cnt_baud = half lands on slot 4*434 + 217 + 1
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4 * 434 + 218, 20);
    g = pop_rx();
    tests++;
    if (g !== 10'h000 || rxq.size() != 0) begin
      fails++;
      $display("FAIL majority got %h extra %0d exp 000 extra 0", g, rxq.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] g;
    cfg(52, 2'd3, 1'b0, 1'b0, 1'b0);
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 20);
    tests++;
    if (rxq.size() != 2) begin fails++; $display("FAIL b2b_count got %0d exp 2", rxq.size()); end
    g = pop_rx();
    tests++;
    if (g !== 10'h000) begin fails++; $display("FAIL b2b_first got %h exp 000", g); end
    g = pop_rx();
    tests++;
    if (g !== 10'h0FF) begin fails++; $display("FAIL b2b_second got %h exp 0ff", g); end
  endtask

  task automatic test_5o1();
    logic [9:0] g;
    cfg(52, 2'd0, 1'b1, 1'b1, 1'b0);
    // five ones with odd parity -> parity bit 0; upper data bits must read back 0
    send_frame(8'hFF, 5, 1'b1, 1'b0, 1'b0, 1'b1, -1, 20);
    g = pop_rx();
    tests++;
    if (g !== 10'h01F || rxq.size() != 0) begin
      fails++;
      $display("FAIL 5o1 got %h extra %0d exp 01f extra 0", g, rxq.size());
    end
  endtask

  task automatic test_clamp();
    logic [9:0] g;
    cfg(3, 2'd3, 1'b0, 1'b0, 1'b0);
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 20);
    g = pop_rx();
    tests++;
    if (g !== 10'h096 || rxq.size() != 0) begin
      fails++;
      $display("FAIL clamp got %h extra %0d exp 096 extra 0", g, rxq.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] g;
    cfg(52, 2'd3, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 52 * 4; c++) begin
      @(negedge clk);
      rx_din = (c < 52) ? 1'b0 : 1'b1;
    end
    rst_n = 1'b0;
    rx_din = 1'b1;
    @(negedge clk);
    tests++;
    if ({rx_byte_vld, parity_err, frame_err, busy, rx_byte} !== 12'h000) begin
      fails++;
      $display("FAIL rstmid_outputs got %h exp 000", {rx_byte_vld, parity_err, frame_err, busy, rx_byte});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (600) @(negedge clk);
    tests++;
    if (rxq.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_discard got q %0d busy %b exp q 0 busy 0", rxq.size(), busy);
    end
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 20);
    g = pop_rx();
    tests++;
    if (g !== 10'h0C3 || rxq.size() != 0) begin
      fails++;
      $display("FAIL rstmid_next got %h extra %0d exp 0c3 extra 0", g, rxq.size());
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e1();
    test_8n2();
    test_false_start();
    test_majority();
    test_back_to_back();
    test_5o1();
    test_clamp();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Runtime-configurable UART receiver, successor to the fixed 8N1 receiver used on the EEPROM command path.
- Frame: 5–8 data bits, optional even/odd parity, 1 or 2 stop bits.
- Baud: arbitrary divisor instead of four fixed rates.
- Each bit is taken as a 3-sample majority vote.
- Reports parity and framing errors per byte and rejects false starts.
- Feeds the command parser.

Parameters:
DIV_W, 16, width of baud_div (clocks per bit)
SYNC_STAGES, 2, synchroniser flops on rx_din (min 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
baud_div  in  DIV_W  clocks per bit, e.g. 434 for 50 MHz / 115200
data_bits  in  2  0:5, 1:6, 2:7, 3:8 data bits
parity_en  in  1  parity bit present
parity_odd  in  1  1 = odd parity, 0 = even
stop2  in  1  1 = two stop bits
rx_din  in  1  serial line, idle high, asynchronous
rx_byte  out  8  received data, LSB first on line; unused upper bits 0
rx_byte_vld  out  1  one-cycle strobe; rx_byte and error flags valid
parity_err  out  1  parity mismatch for the byte flagged by vld
frame_err  out  1  any stop bit sampled 0 for the byte flagged by vld
busy  out  1  high from start-edge detect until return to IDLE

Behaviour:
- Reset is clk, rst_n, asynchronous active-low. All outputs reset to 0. State resets to IDLE, counters to 0, synchroniser to all-1s so reset release gives no false edge.
- Input path: rx_din passes through SYNC_STAGES flops. The falling edge is detected on the last two stages.
- Config latch: baud_div, data_bits, parity_en, parity_odd and stop2 are latched on the start edge. Changes mid-frame have no effect.
- Divisor clamp: a latched baud_div below 8 is clamped to 8.
- Bit timing: cnt_baud counts 0..baud_div-1 per bit. half = baud_div>>1.
- Majority sampling: synchronised samples are taken at cnt_baud = half-1, half and half+1. The bit value is the majority of the three, decided at half+1.
- State machine: IDLE -> START -> DATA -> (PARITY if parity_en) -> STOP -> IDLE.
- IDLE: busy=0. Enter START on falling edge; cnt_baud=0, busy=1.
- START: if the start-bit majority is 1, it is a false start. Return to IDLE at the decision cycle with no vld and no error flags.
- DATA: shift in data_bits+5 bits, LSB first, into rx_byte[n].
- PARITY: expected = XOR(data bits) XOR parity_odd. parity_err = (sampled != expected).
- STOP: one or two stop bits. frame_err = 1 if any stop bit samples 0.
- Output timing: at the decision cycle of the last stop bit, rx_byte, parity_err and frame_err are registered and rx_byte_vld pulses for exactly 1 cycle. State returns to IDLE the same cycle. This gives back-to-back frames half a bit of margin.
- Output hold: rx_byte and the error flags hold until the next vld. Errors are never sticky across bytes. A byte with errors is still delivered.
- Break (line held low): after a frame_err, no new start is accepted until the line returns high and falls again.
- Reset mid-frame: frame is discarded, outputs return to reset values. The next complete frame is received normally.

Decomposition:
- Shared header param.v: state encodings, data_bits encodings, standard divisors (DIV_115200=434, DIV_9600=5208 at 50 MHz). The old BAUD_* constants remain there.
- One sub-module, uart_rx_sampler: synchroniser, falling-edge detect, 3-sample majority. It outputs a bit value and a sample-valid strobe given cnt_baud and half.
- Top module keeps the FSM, counters, shift register, parity and output registers.
- Target size ~200–300 lines.

Test Plan:
- 8N1, baud_div=434, send 0xA5 -> one vld pulse, rx_byte=0xA5, parity_err=0, frame_err=0, busy low after frame.
- 7E1, send 0x35 with parity bit 0 -> rx_byte=0x35, no errors. Repeat with parity bit 1 -> rx_byte=0x35, parity_err=1.
- 8N2, second stop bit driven 0 -> rx_byte correct, frame_err=1. Next frame 0x3C with good stops -> frame_err=0.
- False start: 100-clock low pulse at baud_div=434 -> no vld, busy returns 0. A following 0x5A frame is received correctly.
- Majority: 1-clock inverted glitch at cnt_baud=half on data bit 3 of 0x00 -> rx_byte=0x00.
- Back-to-back 0x00 then 0xFF with no idle, 5O1 (0x1F), and rst_n pulsed mid-frame -> each received byte correct with a single vld each. The aborted frame yields no vld and outputs are zero after reset.
